sram_banked_gated: RTL and testbench

Parametrised single-port scratchpad built from NUM_BANKS equal SRAM banks. Each bank has its own clock gate, opened only in cycles where that bank is accessed or initialised. A post-reset sequencer zero-fills every word before the first request is granted. The block replaces the fixed 1024x32 gated SRAM wrapper in the MAC-engine L1 buffers and adds byte enables, a req/gnt/rvalid handshake and multi-bank scaling.

---
 rtl/sram_banked_gated_if.sv | 28 ++
 rtl/sram_banked_gated.sv | 154 +++++++++++++++
 tb/tb_sram_banked_gated.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_banked_gated_if.sv
// sram_banked_gated_if: request/grant/rvalid bus plus scan and init status for the banked scratchpad.
// Latency: none, signal bundle only.
// Backpressure: master holds req_i until gnt_o; slave drives gnt_o, rvalid_o, rdata_o, init_done_o.
interface sram_banked_gated_if #(
    parameter int AW         = 12,
    parameter int DATA_WIDTH = 32
);
    logic                    scan_en_i;
    logic                    req_i;
    logic                    we_i;
    logic [AW-1:0]           addr_i;
    logic [DATA_WIDTH/8-1:0] be_i;
    logic [DATA_WIDTH-1:0]   wdata_i;
    logic                    gnt_o;
    logic                    rvalid_o;
    logic [DATA_WIDTH-1:0]   rdata_o;
    logic                    init_done_o;

    modport master (
        output scan_en_i, req_i, we_i, addr_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, init_done_o
    );

    modport slave (
        input  scan_en_i, req_i, we_i, addr_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, init_done_o
    );
endinterface

// File: rtl/sram_banked_gated.sv
// sram_banked_gated: NUM_BANKS-bank single-port scratchpad, per-bank clock gate, post-reset zero-fill.
// Latency: read data/rvalid 1 cycle after the accepting edge; 2 when SRAM_BANKED_GATED_OUT_REG_EN is defined.
// Backpressure: gnt_o low during zero-fill or scan_en_i; no queueing, requester holds req_i until granted.
module sram_banked_gated #(
    parameter int NUM_WORDS  = 4096,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BANKS  = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    sram_banked_gated_if.slave bus
);
    localparam int BANK_WORDS = NUM_WORDS / NUM_BANKS;
    localparam int AW         = $clog2(NUM_WORDS);
    localparam int NBE        = DATA_WIDTH / 8;
    localparam int BBITS      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int WBITS      = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_IDLE = 1'b1;

    logic [0:0]       r_state;
    logic [WBITS-1:0] r_cnt;
    logic [BBITS-1:0] r_bank_sel;
    logic             r_rvalid;

    logic                                 w_init;
    logic                                 w_idle;
    logic                                 w_acc;
    logic                                 w_rd_acc;
    logic [BBITS-1:0]                     w_bank;
    logic [WBITS-1:0]                     w_word;
    logic [NUM_BANKS-1:0]                 w_gate_en;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] w_q;
    logic [DATA_WIDTH-1:0]                w_mux;

    // Bank is the top address field, word is the bottom field; a single bank has no bank field.
    generate
        if (NUM_BANKS > 1) begin : g_bank_dec
            assign w_bank = bus.addr_i[AW-1 -: BBITS];
        end else begin : g_one_bank
            assign w_bank = '0;
        end
        if (BANK_WORDS > 1) begin : g_word_dec
            assign w_word = bus.addr_i[WBITS-1:0];
        end else begin : g_one_word
            assign w_word = '0;
        end
    endgenerate

    assign w_init   = (r_state == ST_INIT);
    assign w_idle   = (r_state == ST_IDLE);
    assign w_acc    = bus.req_i && bus.gnt_o;
    assign w_rd_acc = w_acc && !bus.we_i;

    assign bus.gnt_o       = w_idle && !bus.scan_en_i;
    assign bus.init_done_o = w_idle;

    // Gate enable per bank: every bank during zero-fill, only the addressed bank on an accepted access,
    // nothing while scan is active. In silicon this feeds the bank's ICG; here it is the bank clock enable.
    always_comb begin
        w_gate_en = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_gate_en[b] = !bus.scan_en_i && (w_init || (w_acc && (w_bank == BBITS'(b))));
        end
    end

    // Zero-fill sequencer: one word per unpaused cycle in all banks, then IDLE until the next reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else if (w_init && !bus.scan_en_i) begin
            if (r_cnt == WBITS'(BANK_WORDS - 1)) begin
                r_state <= ST_IDLE;
            end
            r_cnt <= r_cnt + 1'b1;
        end
    end

    generate
        for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
            logic [DATA_WIDTH-1:0] r_mem [BANK_WORDS];
            logic [DATA_WIDTH-1:0] r_q;
            logic [WBITS-1:0]      w_idx;

            assign w_idx = w_init ? r_cnt : w_word;

            // Array write on gated cycles only: zeros during fill, byte-masked data otherwise.
            always_ff @(posedge clk_i) begin
                if (w_gate_en[gb]) begin
                    for (int k = 0; k < NBE; k++) begin
                        if (w_init) begin
                            r_mem[w_idx][8*k +: 8] <= 8'h00;
                        end else if (bus.we_i && bus.be_i[k]) begin
                            r_mem[w_idx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
                        end
                    end
                end
            end

            // Bank Q register: loads only on an accepted read of this bank, holds across writes.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_q <= '0;
                end else if (w_gate_en[gb] && !w_init && !bus.we_i) begin
                    r_q <= r_mem[w_idx];
                end
            end

            assign w_q[gb] = r_q;
        end
    endgenerate

    // Remember which bank answered so the output mux follows the Q that just loaded.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid   <= 1'b0;
            r_bank_sel <= '0;
        end else begin
            r_rvalid <= w_rd_acc;
            if (w_rd_acc) begin
                r_bank_sel <= w_bank;
            end
        end
    end

    assign w_mux = w_q[r_bank_sel];

`ifdef SRAM_BANKED_GATED_OUT_REG_EN
    logic                  r_rvalid_d;
    logic [DATA_WIDTH-1:0] r_rdata_d;

    // Extra output stage after the mux; data captured only on a read response so it holds otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid_d <= 1'b0;
            r_rdata_d  <= '0;
        end else begin
            r_rvalid_d <= r_rvalid;
            if (r_rvalid) begin
                r_rdata_d <= w_mux;
            end
        end
    end

    assign bus.rvalid_o = r_rvalid_d;
    assign bus.rdata_o  = r_rdata_d;
`else
    // Mux output is stable between reads: Q and bank select only move on a read.
    assign bus.rvalid_o = r_rvalid;
    assign bus.rdata_o  = w_mux;
`endif
endmodule

// File: tb/tb_sram_banked_gated.sv
// tb_sram_banked_gated: randomized and directed stimulus against a behavioural memory model.
// Latency: model expects rvalid LAT cycles after acceptance (LAT follows SRAM_BANKED_GATED_OUT_REG_EN).
// Backpressure: model grants only after zero-fill and with scan low.
module tb_sram_banked_gated;
    localparam int NW     = 4096;
    localparam int DW     = 32;
    localparam int NB     = 4;
    localparam int BWORDS = NW / NB;
    localparam int AW     = 12;
`ifdef SRAM_BANKED_GATED_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    sram_banked_gated_if #(.AW(AW), .DATA_WIDTH(DW)) bus ();

    sram_banked_gated #(.NUM_WORDS(NW), .DATA_WIDTH(DW), .NUM_BANKS(NB)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    typedef struct {
        int          due;
        logic [DW-1:0] data;
    } rsp_t;

    logic [DW-1:0] m_mem [NW];
    int            m_init_left;
    int            cyc;
    rsp_t          m_rsp [$];
    logic [DW-1:0] m_rdata;
    logic [AW-1:0] wr_addrs [$];

    int checks = 0;
    int errors = 0;

    logic          obs_gnt, obs_rv, obs_done;
    logic [DW-1:0] obs_rd;
    logic [NB-1:0] obs_gate;
    logic          exp_gnt, exp_rv, exp_done;
    logic [DW-1:0] exp_rd;
    logic [NB-1:0] exp_gate;

    task automatic model_reset();
        for (int i = 0; i < NW; i++) m_mem[i] = '0;
        m_init_left = BWORDS;
        m_rsp.delete();
        m_rdata = '0;
    endtask

    task automatic drive_idle();
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0;
        bus.be_i = '0; bus.wdata_i = '0; bus.scan_en_i = 1'b0;
    endtask

    task automatic reset_assert();
        rst_ni = 1'b0;
        drive_idle();
        model_reset();
        @(negedge clk_i);
    endtask

    task automatic reset_release();
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    // One bus cycle: drive, sample mid-cycle, advance the model by the rules of the block.
    task automatic step(input logic req, input logic we, input logic [AW-1:0] addr,
                        input logic [DW/8-1:0] be, input logic [DW-1:0] wd, input logic scan);
        bus.req_i = req; bus.we_i = we; bus.addr_i = addr;
        bus.be_i = be; bus.wdata_i = wd; bus.scan_en_i = scan;
        @(negedge clk_i);
        obs_gnt  = bus.gnt_o;
        obs_rv   = bus.rvalid_o;
        obs_rd   = bus.rdata_o;
        obs_done = bus.init_done_o;
        obs_gate = dut.w_gate_en;
        exp_done = (m_init_left == 0);
        exp_gnt  = exp_done && !scan;
        exp_rv   = (m_rsp.size() > 0) && (m_rsp[0].due == cyc);
        if (exp_rv) begin
            m_rdata = m_rsp[0].data;
            void'(m_rsp.pop_front());
        end
        exp_rd   = m_rdata;
        exp_gate = '0;
        if (!scan) begin
            if (!exp_done) exp_gate = '1;
            else if (req) exp_gate[int'(addr) / BWORDS] = 1'b1;
        end
        if (exp_gnt && req) begin
            if (we) begin
                for (int k = 0; k < DW/8; k++)
                    if (be[k]) m_mem[addr][8*k +: 8] = wd[8*k +: 8];
            end else begin
                m_rsp.push_back('{due: cyc + LAT, data: m_mem[addr]});
            end
        end
        if (!exp_done && !scan) m_init_left--;
        cyc++;
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        int first_done;
        int pulses;
        logic [AW-1:0] rd_addr [4];
        rd_addr[0] = 12'd0; rd_addr[1] = 12'd1023; rd_addr[2] = 12'd1024; rd_addr[3] = 12'd4095;
        reset_assert();
        checks++;
        if ({bus.gnt_o, bus.rvalid_o, bus.rdata_o, bus.init_done_o} !== {1'b0, 1'b0, {DW{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL reset_values gnt/rv/rdata/done got %b/%b/%h/%b want 0/0/0/0",
                     bus.gnt_o, bus.rvalid_o, bus.rdata_o, bus.init_done_o);
        end
        reset_release();
        first_done = -1;
        for (int i = 0; i < BWORDS + 2; i++) begin
            step(1'b1, 1'b0, 12'd0, '0, '0, 1'b0);
            checks++;
            if ({obs_gnt, obs_rv, obs_rd, obs_gate, obs_done} !== {exp_gnt, exp_rv, exp_rd, exp_gate, exp_done}) begin
                errors++;
                $display("FAIL init_cycle%0d gnt/rv/rdata/gate/done got %b/%b/%h/%b/%b want %b/%b/%h/%b/%b",
                         i, obs_gnt, obs_rv, obs_rd, obs_gate, obs_done, exp_gnt, exp_rv, exp_rd, exp_gate, exp_done);
            end
            if (obs_done && first_done < 0) first_done = i;
        end
        checks++;
        if (first_done != BWORDS) begin
            errors++;
            $display("FAIL init_latency got %0d want %0d", first_done, BWORDS);
        end
        for (int i = 0; i < LAT + 6; i++) step(0, 0, 0, 0, 0, 0);
        pulses = 0;
        for (int i = 0; i < 4 + LAT + 1; i++) begin
            if (i < 4) step(1'b1, 1'b0, rd_addr[i], '0, '0, 1'b0);
            else       step(1'b0, 1'b0, '0, '0, '0, 1'b0);
            checks++;
            if ({obs_gnt, obs_rv, obs_rd, obs_gate} !== {exp_gnt, exp_rv, exp_rd, exp_gate}) begin
                errors++;
                $display("FAIL zero_read_cycle%0d gnt/rv/rdata/gate got %b/%b/%h/%b want %b/%b/%h/%b",
                         i, obs_gnt, obs_rv, obs_rd, obs_gate, exp_gnt, exp_rv, exp_rd, exp_gate);
            end
            if (obs_rv) begin
                pulses++;
                checks++;
                if (obs_rd !== '0) begin
                    errors++;
                    $display("FAIL zero_read_data got %h want 0", obs_rd);
                end
            end
        end
        checks++;
        if (pulses != 4) begin
            errors++;
            $display("FAIL zero_read_pulses got %0d want 4", pulses);
        end
    endtask

    task automatic test_byte_enable();
        int pulses;
        int rv_at;
        logic [DW-1:0] want;
        logic [DW-1:0] got;
        want = 32'hDE22BE44;
        got = '0;
        pulses = 0;
        rv_at = -1;
        for (int i = 0; i < 3 + LAT + 1; i++) begin
            case (i)
                0:       step(1'b1, 1'b1, 12'h805, 4'b1111, 32'hDEADBEEF, 1'b0);
                1:       step(1'b1, 1'b1, 12'h805, 4'b0101, 32'h11223344, 1'b0);
                2:       step(1'b1, 1'b0, 12'h805, 4'b0000, 32'h0, 1'b0);
                default: step(1'b0, 1'b0, 12'h0, 4'b0000, 32'h0, 1'b0);
            endcase
            checks++;
            if ({obs_gnt, obs_rv, obs_rd, obs_gate} !== {exp_gnt, exp_rv, exp_rd, exp_gate}) begin
                errors++;
                $display("FAIL byte_en_cycle%0d gnt/rv/rdata/gate got %b/%b/%h/%b want %b/%b/%h/%b",
                         i, obs_gnt, obs_rv, obs_rd, obs_gate, exp_gnt, exp_rv, exp_rd, exp_gate);
            end
            if (obs_rv) begin
                pulses++;
                rv_at = i;
                got = obs_rd;
            end
        end
        checks++;
        if (pulses != 1 || rv_at != 2 + LAT || got !== want) begin
            errors++;
            $display("FAIL byte_en_result pulses/at/data got %0d/%0d/%h want 1/%0d/%h",
                     pulses, rv_at, got, 2 + LAT, want);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a2, a3;
        logic [NB-1:0] gate_want;
        int first_rv;
        int pulses;
        a2 = 12'h800 | AW'($urandom_range(BWORDS - 1));
        a3 = 12'hC00 | AW'($urandom_range(BWORDS - 1));
        step(1'b1, 1'b1, a2, 4'hF, $urandom, 1'b0);
        step(1'b1, 1'b1, a3, 4'hF, $urandom, 1'b0);
        first_rv = -1;
        pulses = 0;
        for (int i = 0; i < 2 + LAT + 1; i++) begin
            if (i == 0)      step(1'b1, 1'b0, a2, '0, '0, 1'b0);
            else if (i == 1) step(1'b1, 1'b0, a3, '0, '0, 1'b0);
            else             step(1'b0, 1'b0, '0, '0, '0, 1'b0);
            checks++;
            if ({obs_gnt, obs_rv, obs_rd, obs_gate} !== {exp_gnt, exp_rv, exp_rd, exp_gate}) begin
                errors++;
                $display("FAIL b2b_cycle%0d gnt/rv/rdata/gate got %b/%b/%h/%b want %b/%b/%h/%b",
                         i, obs_gnt, obs_rv, obs_rd, obs_gate, exp_gnt, exp_rv, exp_rd, exp_gate);
            end
            if (i < 2) begin
                gate_want = (i == 0) ? 4'b0100 : 4'b1000;
                checks++;
                if (obs_gate !== gate_want) begin
                    errors++;
                    $display("FAIL b2b_gate%0d got %b want %b", i, obs_gate, gate_want);
                end
            end
            if (obs_rv) begin
                pulses++;
                if (first_rv < 0) first_rv = i;
            end
        end
        checks++;
        if (pulses != 2 || first_rv != LAT) begin
            errors++;
            $display("FAIL b2b_pulses count/first got %0d/%0d want 2/%0d", pulses, first_rv, LAT);
        end
    endtask

    task automatic test_scan_idle();
        logic [AW-1:0] a;
        a = AW'($urandom_range(NW - 1));
        for (int i = 0; i < 4 + LAT + 1; i++) begin
            if (i < 3)       step(1'b1, 1'b0, a, '0, '0, 1'b1);
            else if (i == 3) step(1'b1, 1'b0, a, '0, '0, 1'b0);
            else             step(1'b0, 1'b0, '0, '0, '0, 1'b0);
            checks++;
            if ({obs_gnt, obs_rv, obs_rd, obs_gate} !== {exp_gnt, exp_rv, exp_rd, exp_gate}) begin
                errors++;
                $display("FAIL scan_idle_cycle%0d gnt/rv/rdata/gate got %b/%b/%h/%b want %b/%b/%h/%b",
                         i, obs_gnt, obs_rv, obs_rd, obs_gate, exp_gnt, exp_rv, exp_rd, exp_gate);
            end
            if (i <= 3) begin
                checks++;
                if (obs_gnt !== (i == 3)) begin
                    errors++;
                    $display("FAIL scan_idle_gnt%0d got %b want %b", i, obs_gnt, (i == 3));
                end
            end
        end
    endtask

    task automatic test_random();
        logic          req, we, scan;
        logic [AW-1:0] a;
        logic [3:0]    be;
        for (int i = 0; i < 400 + LAT + 1; i++) begin
            req  = (i < 400) && ($urandom_range(9) < 7);
            we   = $urandom_range(1);
            scan = (i < 400) && ($urandom_range(9) == 0);
            a    = AW'($urandom_range(NW - 1));
            be   = 4'($urandom_range(15));
            step(req, we, a, be, $urandom, scan);
            if (exp_gnt && req && we && be != 0) wr_addrs.push_back(a);
            checks++;
            if ({obs_gnt, obs_rv, obs_rd, obs_gate} !== {exp_gnt, exp_rv, exp_rd, exp_gate}) begin
                errors++;
                $display("FAIL random_cycle%0d gnt/rv/rdata/gate got %b/%b/%h/%b want %b/%b/%h/%b",
                         i, obs_gnt, obs_rv, obs_rd, obs_gate, exp_gnt, exp_rv, exp_rd, exp_gate);
            end
        end
    endtask

    task automatic test_reset_mid_init();
        int n;
        reset_assert();
        reset_release();
        for (int i = 0; i < 500; i++) step(0, 0, 0, 0, 0, 0);
        reset_assert();
        checks++;
        if ({bus.gnt_o, bus.rvalid_o, bus.rdata_o, bus.init_done_o} !== {1'b0, 1'b0, {DW{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_values gnt/rv/rdata/done got %b/%b/%h/%b want 0/0/0/0",
                     bus.gnt_o, bus.rvalid_o, bus.rdata_o, bus.init_done_o);
        end
        reset_release();
        for (int i = 0; i < BWORDS + 1; i++) begin
            step(0, 0, 0, 0, 0, 0);
            checks++;
            if ({obs_gnt, obs_done, obs_gate} !== {exp_gnt, exp_done, exp_gate}) begin
                errors++;
                $display("FAIL restart_cycle%0d gnt/done/gate got %b/%b/%b want %b/%b/%b",
                         i, obs_gnt, obs_done, obs_gate, exp_gnt, exp_done, exp_gate);
            end
        end
        n = (wr_addrs.size() < 12) ? wr_addrs.size() : 12;
        for (int i = 0; i < n + LAT + 1; i++) begin
            if (i < n) step(1'b1, 1'b0, wr_addrs[i], '0, '0, 1'b0);
            else       step(1'b0, 1'b0, '0, '0, '0, 1'b0);
            checks++;
            if ({obs_gnt, obs_rv, obs_rd} !== {exp_gnt, exp_rv, exp_rd} || (obs_rv && obs_rd !== '0)) begin
                errors++;
                $display("FAIL restart_read%0d gnt/rv/rdata got %b/%b/%h want %b/%b/%h",
                         i, obs_gnt, obs_rv, obs_rd, exp_gnt, exp_rv, {DW{1'b0}});
            end
        end
    endtask

    task automatic test_scan_init();
        int first_done;
        first_done = -1;
        reset_assert();
        reset_release();
        for (int i = 0; i < BWORDS + 40 && first_done < 0; i++) begin
            step(1'b0, 1'b0, '0, '0, '0, (i >= 100 && i < 110));
            checks++;
            if ({obs_gnt, obs_done, obs_gate} !== {exp_gnt, exp_done, exp_gate}) begin
                errors++;
                $display("FAIL scan_init_cycle%0d gnt/done/gate got %b/%b/%b want %b/%b/%b",
                         i, obs_gnt, obs_done, obs_gate, exp_gnt, exp_done, exp_gate);
            end
            if (obs_done) first_done = i;
        end
        checks++;
        if (first_done != BWORDS + 10) begin
            errors++;
            $display("FAIL scan_init_latency got %0d want %0d", first_done, BWORDS + 10);
        end
        for (int i = 0; i < 8 + LAT + 1; i++) begin
            if (i < 8) step(1'b1, 1'b0, AW'($urandom_range(NW - 1)), '0, '0, 1'b0);
            else       step(1'b0, 1'b0, '0, '0, '0, 1'b0);
            checks++;
            if ({obs_rv, obs_rd} !== {exp_rv, exp_rd} || (obs_rv && obs_rd !== '0)) begin
                errors++;
                $display("FAIL scan_init_read%0d rv/rdata got %b/%h want %b/%h",
                         i, obs_rv, obs_rd, exp_rv, {DW{1'b0}});
            end
        end
    endtask

    initial begin
        cyc = 0;
        drive_idle();
        model_reset();
        test_reset();
        test_byte_enable();
        test_back_to_back();
        test_scan_idle();
        test_random();
        test_reset_mid_init();
        test_scan_init();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
